// File: rtl/enigma_multi.sv
// Multi-rotor Enigma-style cipher. Each rotor is a loadable substitution table,
// and the reflector is the fixed map x -> M-1-x. One symbol is processed per cycle.
module enigma_multi #(
  parameter int SYM_W = 6,
  parameter int NROT  = 3,
  localparam int M    = 1 << SYM_W,
  localparam int RW   = (NROT > 1) ? $clog2(NROT) : 1
) (
  input  logic                clk,
  input  logic                srstn,
  input  logic                load,
  input  logic [RW+SYM_W-1:0] load_idx,
  input  logic [SYM_W-1:0]    code_in,
  input  logic                encrypt,
  input  logic                crypt_mode,
  output logic [SYM_W-1:0]    code_out,
  output logic                code_valid,
  output logic                ready
);

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

  state_t            state, state_next;
  logic [SYM_W-1:0]  tbl [NROT][M];
  logic [SYM_W-1:0]  pos [NROT];
  logic [NROT-1:0]   step;
  logic [RW-1:0]     sel;
  logic [SYM_W-1:0]  entry;
  logic              accept, wr_en, clear_pos;
  logic [SYM_W-1:0]  fwd_v, inv_v, nv, result;

  assign sel       = load_idx[RW+SYM_W-1:SYM_W];
  assign entry     = load_idx[SYM_W-1:0];
  assign accept    = (state == READY) && encrypt && !load;
  assign wr_en     = (state == LOAD) && load;
  assign clear_pos = ((state == LOAD) && !load) || ((state == READY) && load);
  assign ready     = (state == READY);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = LOAD;
      LOAD:    if (!load) state_next = READY;
      READY:   if (load) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  // Odometer carry: rotor k advances only when every lower rotor advances from M-1.
  always_comb begin
    step    = '0;
    step[0] = accept;
    for (int k = 1; k < NROT; k++)
      step[k] = step[k-1] & crypt_mode & (pos[k-1] == '1);
  end

  // Forward pass, reflector (bitwise NOT equals M-1-x), then inverse pass.
  always_comb begin
    fwd_v = code_in;
    for (int k = 0; k < NROT; k++)
      fwd_v = tbl[RW'(k)][fwd_v];
    inv_v = ~fwd_v;
    nv    = '0;
    for (int k = NROT - 1; k >= 0; k--) begin
      nv = '0;
      // Descending scan so the lowest matching index wins.
      for (int i = M - 1; i >= 0; i--)
        if (tbl[RW'(k)][SYM_W'(i)] == inv_v) nv = SYM_W'(i);
      inv_v = nv;
    end
    result = inv_v;
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state      <= IDLE;
      code_out   <= '0;
      code_valid <= 1'b0;
      for (int k = 0; k < NROT; k++)
        pos[k] <= '0;
    end else begin
      state      <= state_next;
      code_valid <= accept;
      if (accept) code_out <= result;
      for (int k = 0; k < NROT; k++) begin
        if (clear_pos)    pos[k] <= '0;
        else if (step[k]) pos[k] <= pos[k] + 1'b1;
      end
    end
  end

  // Tables survive reset; a rotation shifts every entry up by one index.
  always_ff @(posedge clk) begin
    if (srstn) begin
      for (int k = 0; k < NROT; k++) begin
        if (step[k]) begin
          for (int i = 0; i < M; i++)
            tbl[RW'(k)][SYM_W'(i)] <= tbl[RW'(k)][SYM_W'((i + M - 1) % M)];
        end else if (wr_en && sel == RW'(k)) begin
          tbl[RW'(k)][entry] <= code_in;
        end
      end
    end
  end

endmodule
